// File: rtl/amba3_apb_sram_slave.sv
// AMBA 3 APB completer backed by a word-addressed register array, with
// address-range error responses, fixed or LFSR-derived wait states and a saturating error counter.
module amba3_apb_sram_slave #(
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   DATA_SIZE   = 32,
  parameter int                   DEPTH       = 256,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = {ADDR_SIZE{1'b0}},
  parameter int                   WAIT_STATES = 0,
  parameter int                   WAIT_MODE   = 0
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic                 pready,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pslverr,
  output logic [15:0]          err_count
);

  localparam int LSB = $clog2(DATA_SIZE / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((64'd1 << LSB) - 64'd1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_A = ADDR_SIZE'(DEPTH);
  localparam logic [4:0] WAIT_MOD = 5'(WAIT_STATES + 1);
  localparam logic [DATA_SIZE-1:0] DATA_ZERO = {DATA_SIZE{1'b0}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [7:0]           lfsr_r;
  logic [7:0]           lfsr_nxt_s;
  logic [3:0]           wait_cnt_r;
  logic [3:0]           wait_s;
  logic                 pwrite_r;
  logic                 err_r;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     rd_idx_s;
  logic [ADDR_SIZE-1:0] off_s;
  logic [ADDR_SIZE-1:0] idx_full_s;
  logic                 err_s;
  logic                 setup_s;
  logic                 complete_s;
  logic                 abort_s;
  logic [DATA_SIZE-1:0] rd_word_s;
  logic                 pready_r;
  logic                 pslverr_r;
  logic [DATA_SIZE-1:0] prdata_r;
  logic [15:0]          err_count_r;

  assign pready    = pready_r;
  assign pslverr   = pslverr_r;
  assign prdata    = prdata_r;
  assign err_count = err_count_r;

  // Address decode, wait-count source and array read port
  always_comb begin
    off_s      = paddr - BASE_ADDR;
    idx_full_s = off_s >> LSB;
    err_s      = ((off_s & ALIGN_MASK) != ADDR_ZERO) || (paddr < BASE_ADDR) ||
                 (idx_full_s >= DEPTH_A);
    lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    if (WAIT_MODE == 0) begin
      wait_s = 4'(WAIT_STATES);
    end else begin
      wait_s = 4'({1'b0, lfsr_r[3:0]} % WAIT_MOD);
    end
    // zero-wait reads fetch on the setup edge, before idx_r is loaded
    if (setup_s) begin
      rd_idx_s = idx_full_s[IDX_W-1:0];
    end else begin
      rd_idx_s = idx_r;
    end
    rd_word_s = mem_r[rd_idx_s];
  end

  // Control FSM next state and transfer events
  always_comb begin
    state_nxt_s = state_r;
    setup_s     = 1'b0;
    complete_s  = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (psel && !penable) begin
          setup_s     = 1'b1;
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (penable && pready_r) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched transfer context, wait counter, response outputs and error counter
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      prdata_r    <= DATA_ZERO;
      err_count_r <= 16'd0;
      lfsr_r      <= 8'hA5;
      wait_cnt_r  <= 4'd0;
      pwrite_r    <= 1'b0;
      err_r       <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
    end else if (setup_s) begin
      pwrite_r   <= pwrite;
      err_r      <= err_s;
      idx_r      <= idx_full_s[IDX_W-1:0];
      wait_cnt_r <= wait_s;
      lfsr_r     <= lfsr_nxt_s;
      if (wait_s == 4'd0) begin
        pready_r  <= 1'b1;
        pslverr_r <= err_s;
        prdata_r  <= (!pwrite && !err_s) ? rd_word_s : DATA_ZERO;
      end else begin
        pready_r  <= 1'b0;
        pslverr_r <= 1'b0;
        prdata_r  <= DATA_ZERO;
      end
    end else if (abort_s || complete_s) begin
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      prdata_r   <= DATA_ZERO;
      wait_cnt_r <= 4'd0;
      if (complete_s && err_r && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end
    end else if ((state_r == ST_ACCESS) && !pready_r) begin
      // pready rises on the edge that ends the last wait cycle
      if (wait_cnt_r == 4'd1) begin
        pready_r  <= 1'b1;
        pslverr_r <= err_r;
        prdata_r  <= (!pwrite_r && !err_r) ? rd_word_s : DATA_ZERO;
      end
      wait_cnt_r <= wait_cnt_r - 4'd1;
    end
  end

  // Storage array: written only on an error-free write completion, never cleared
  always_ff @(posedge pclk) begin
    if (!preset && complete_s && pwrite_r && !err_r) begin
      mem_r[idx_r] <= pwdata;
    end
  end

endmodule

// File: tb/tb_amba3_apb_sram_slave.sv
// Randomized self-checking bench: four differently configured completers on a
// shared APB bus, checked against an array/LFSR reference model of the access rules.
module tb_amba3_apb_sram_slave;

  logic        pclk;
  logic        preset;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pready;
  logic [31:0] prdata [4];
  logic [3:0]  pslverr;
  logic [15:0] err_count [4];

  int          checks_cnt;
  int          errors_cnt;
  logic [31:0] mem_m [4][256];
  bit          valid_m [4][256];
  int          err_m [4];
  logic [7:0]  lfsr_m [4];

  amba3_apb_sram_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(256), .BASE_ADDR(32'h0),
    .WAIT_STATES(0), .WAIT_MODE(0)) u_dut0 (.pclk(pclk), .preset(preset), .psel(psel[0]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .err_count(err_count[0]));
  amba3_apb_sram_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(256), .BASE_ADDR(32'h0),
    .WAIT_STATES(3), .WAIT_MODE(0)) u_dut1 (.pclk(pclk), .preset(preset), .psel(psel[1]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .err_count(err_count[1]));
  amba3_apb_sram_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(7), .WAIT_MODE(1)) u_dut2 (.pclk(pclk), .preset(preset), .psel(psel[2]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready[2]),
    .prdata(prdata[2]), .pslverr(pslverr[2]), .err_count(err_count[2]));
  amba3_apb_sram_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(64), .BASE_ADDR(32'h0),
    .WAIT_STATES(4), .WAIT_MODE(0)) u_dut3 (.pclk(pclk), .preset(preset), .psel(psel[3]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready[3]),
    .prdata(prdata[3]), .pslverr(pslverr[3]), .err_count(err_count[3]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic int ws_of(input int d);
    case (d)
      0: return 0;
      1: return 3;
      2: return 7;
      default: return 4;
    endcase
  endfunction

  function automatic int depth_of(input int d);
    case (d)
      2: return 16;
      3: return 64;
      default: return 256;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000 : 32'h0;
  endfunction

  function automatic bit addr_err(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(d);
    return (off[1:0] != 2'b00) || (a < base_of(d)) || ((off >> 2) >= 32'(depth_of(d)));
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected wait count for the next setup phase; steps the reference LFSR.
  task automatic model_wait(input int d, output int w);
    if (d == 2) w = int'(lfsr_m[d][3:0]) % (ws_of(d) + 1);
    else        w = ws_of(d);
    lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      err_m[d]  = 0;
      lfsr_m[d] = 8'hA5;
    end
  endtask

  // One complete APB transfer to completer d; leaves the bus idle #1 after completion.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bit          exp_err;
    int          exp_w;
    int          waits;
    int          idx;
    logic [31:0] exp_rd;
    bit          chk_rd;
    exp_err = addr_err(d, addr);
    model_wait(d, exp_w);
    idx     = exp_err ? 0 : int'((addr - base_of(d)) >> 2);
    chk_rd  = !wr && (exp_err || valid_m[d][idx]);
    exp_rd  = exp_err ? 32'h0 : mem_m[d][idx];
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = $urandom;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = wdata;
    waits   = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      check_val($sformatf("d%0d_wait_prdata", d), prdata[d], 32'h0);
      check_val($sformatf("d%0d_wait_pslverr", d), pslverr[d], 1'b0);
      @(posedge pclk); #1;
      waits++;
    end
    check_val($sformatf("d%0d_waits", d), waits, exp_w);
    if (d == 2) check_val("d2_wait_range", (waits <= 7), 1'b1);
    check_val($sformatf("d%0d_pslverr", d), pslverr[d], exp_err);
    if (chk_rd) check_val($sformatf("d%0d_prdata", d), prdata[d], exp_rd);
    @(posedge pclk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
    if (exp_err) begin
      if (err_m[d] < 65535) err_m[d]++;
    end else if (wr) begin
      mem_m[d][idx]   = wdata;
      valid_m[d][idx] = 1'b1;
    end
    check_val($sformatf("d%0d_pready_drop", d), pready[d], 1'b0);
    check_val($sformatf("d%0d_err_count", d), err_count[d], err_m[d]);
  endtask

  task automatic rand_xfer(input int d, input bit wr);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = base_of(d) + 32'($urandom_range(0, 4 * depth_of(d) + 63));
    else a = base_of(d) + 32'(4 * $urandom_range(0, depth_of(d) - 1));
    apb_xfer(d, wr, a, $urandom);
  endtask

  initial begin
    int w;
    checks_cnt = 0;
    errors_cnt = 0;
    model_reset();
    psel    = 4'b0000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    preset  = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d_rst_pready", d), pready[d], 1'b0);
      check_val($sformatf("d%0d_rst_pslverr", d), pslverr[d], 1'b0);
      check_val($sformatf("d%0d_rst_prdata", d), prdata[d], 32'h0);
      check_val($sformatf("d%0d_rst_err_count", d), err_count[d], 16'h0);
    end
    preset = 1'b0;
    @(posedge pclk); #1;

    // zero-wait completer, then misaligned and random traffic
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
    apb_xfer(0, 1'b0, 32'h10, 32'h0);
    apb_xfer(0, 1'b0, 32'h11, 32'h0);
    apb_xfer(0, 1'b0, 32'h400, 32'h0);
    for (int i = 0; i < 30; i++) rand_xfer(0, 1'($urandom_range(0, 1)));

    // fixed three-wait completer
    apb_xfer(1, 1'b1, 32'h0, 32'h1234_5678);
    apb_xfer(1, 1'b0, 32'h0, 32'h0);

    // abort after one wait cycle on the four-wait completer
    apb_xfer(3, 1'b1, 32'h20, 32'hA5A5_0F0F);
    model_wait(3, w);
    psel[3] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'h0BAD_0BAD;
    @(posedge pclk); #1;
    penable = 1'b1;
    check_val("d3_abort_wait", pready[3], 1'b0);
    @(posedge pclk); #1;
    psel[3] = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    check_val("d3_abort_pready", pready[3], 1'b0);
    @(posedge pclk); #1;
    check_val("d3_abort_pready2", pready[3], 1'b0);
    check_val("d3_abort_err_count", err_count[3], 16'h0);
    apb_xfer(3, 1'b0, 32'h20, 32'h0);

    // error cases and random waits on the offset, LFSR-wait completer
    apb_xfer(2, 1'b1, 32'h1000, 32'hCAFE_F00D);
    apb_xfer(2, 1'b0, 32'h1040, 32'h0);
    apb_xfer(2, 1'b1, 32'h1002, 32'hFFFF_FFFF);
    apb_xfer(2, 1'b0, 32'h0FFC, 32'h0);
    check_val("d2_err_count_3", err_count[2], 16'd3);
    apb_xfer(2, 1'b0, 32'h1000, 32'h0);
    for (int i = 0; i < 100; i++) rand_xfer(2, 1'b1);
    for (int i = 0; i < 100; i++) rand_xfer(2, 1'b0);

    // reset in the middle of a write access on the three-wait completer
    model_wait(1, w);
    psel[1] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0;
    pwdata  = 32'h7777_7777;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset  = 1'b1;
    @(posedge pclk); #1;
    preset  = 1'b0;
    psel    = 4'b0000;
    penable = 1'b0;
    model_reset();
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("d%0d_mid_rst_pready", d), pready[d], 1'b0);
      check_val($sformatf("d%0d_mid_rst_pslverr", d), pslverr[d], 1'b0);
      check_val($sformatf("d%0d_mid_rst_prdata", d), prdata[d], 32'h0);
      check_val($sformatf("d%0d_mid_rst_err_count", d), err_count[d], err_m[d]);
    end
    apb_xfer(1, 1'b0, 32'h0, 32'h0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 10; i++) rand_xfer(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
